imu_read_sequencer: RTL
=======================

// Module: imu_read_sequencer
// PURPOSE
//  Sequences the IMU for the inertial integrator: after power-up it writes the IMU config
//  registers, then on every data-ready interrupt reads pitch rate and Z accel (4 byte reads)
//  through the SPI master's transaction handshake, assembles two signed 16-bit samples and
//  pulses vld. Sits between the SPI master (wrt/cmd/done/rd_data) and inertial_integrator.
// PARAMETERS
//  INIT_WAIT_W   16    width of power-up wait counter; first write after 2^W-1 cycles
//  TIMEOUT_CYC   1024  cycles without done before a transaction is retried (IMU_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  INT          in   1   IMU data-ready, asynchronous to clk
//  done         in   1   SPI master: 1-cycle pulse, transaction complete
//  rd_data      in   16  SPI master read data; only [7:0] used
//  wrt          out  1   SPI master: 1-cycle pulse, start transaction
//  cmd          out  16  SPI command {addr,data}; stable from wrt until done
//  ptch_rt      out  16  signed pitch rate to integrator
//  AZ           out  16  signed Z acceleration to integrator
//  vld          out  1   1-cycle pulse: ptch_rt/AZ updated this cycle
//  init_done    out  1   high once all config writes completed
//  timeout_err  out  1   sticky; exists only with IMU_TIMEOUT_EN
// BEHAVIOUR
//  Reset: all outputs 0, state INIT_WAIT, counters/indices 0, pending flag 0.
//  States: INIT_WAIT -> INIT_WR -> IDLE -> RD -> OUT -> IDLE.
//  INIT_WAIT: counter increments each cycle; at all-ones go INIT_WR, idx=0.
//  INIT_WR: idx 0..3 issues 0x0D02, 0x1053, 0x1150, 0x1460. wrt pulses the cycle after
//   entering a transaction; wait for done; idx++. done of idx 3 -> init_done=1, IDLE.
//  INT: 2-flop synchroniser + rising-edge detect. Edges before init_done are dropped.
//  IDLE: edge or pending flag -> RD idx=0, clear pending.
//  RD: idx 0..3 issues {A2,00},{A3,00},{AC,00},{AD,00} (pitch L/H, AZ L/H). On done,
//   rd_data[7:0] captured into byte reg idx. Edge during RD/OUT sets pending (one deep;
//   further edges merge).
//  OUT: single cycle; ptch_rt={b1,b0}, AZ={b3,b2}, vld=1; next IDLE.
//   Latency: vld rises exactly 1 cycle after done of 4th read. Outputs hold between frames.
//  done outside a waiting transaction is ignored. No wrt while a transaction is outstanding.
//  wrt never coincides with done; minimum one cycle between done and next wrt.
//  Reset mid-operation: immediate abort, return to INIT_WAIT, full re-init required.
// CONFIGURATION
//  IMU_TIMEOUT_EN defined: per-transaction counter cleared on wrt; reaching TIMEOUT_CYC
//   without done sets timeout_err (sticky until rst) and re-issues wrt with same cmd/idx.
//   Bytes captured earlier in the frame are kept.
//  Not defined: sequencer waits on done indefinitely; timeout_err port and counter absent.
// STRUCTURE
//  Package imu_seq_pkg: state enum, INIT_CMD[4] and RD_ADDR[4] constant tables,
//   default TIMEOUT_CYC.
//  Sub-module int_sync_edge: 2-flop synchroniser + rising-edge pulse (async active-high rst).
//  Remaining FSM, counters, byte regs in imu_read_sequencer.
// TESTING (INIT_WAIT_W=4, SPI master modelled: done 20 cycles after wrt)
//  1 Init: release rst -> first wrt 15 cycles later, cmd 0x0D02; then 0x1053,0x1150,0x1460;
//    init_done=1 one cycle after 4th done; INT high before that -> no read.
//  2 Frame: INT edge, bytes 0x34,0x12,0x78,0x56 -> cmds A200,A300,AC00,AD00; vld 1 cycle,
//    ptch_rt=0x1234, AZ=0x5678, held until next frame.
//  3 Sign: bytes 0x00,0xF0,0x00,0x08 -> ptch_rt=0xF000 (-4096), AZ=0x0800.
//  4 Overlap: INT edge during 2nd read -> after vld, IDLE 1 cycle, new frame starts;
//    3 edges during one frame -> exactly one extra frame.
//  5 Reset mid-read: rst during 3rd read -> outputs 0, init_done 0, re-init from 0x0D02.
//  6 IMU_TIMEOUT_EN: withhold done 1024 cycles on AC00 -> timeout_err=1, wrt re-issued
//    with AC00; frame then completes with correct data; err stays 1 until rst.

Source files
------------

// File: rtl/imu_seq_pkg.sv
// Shared types and constant tables for the IMU read sequencer.
package imu_seq_pkg;

   typedef enum logic [2:0] {
      INIT_WAIT,
      INIT_WR,
      IDLE,
      RD,
      OUT
   } seq_state_t;

   // Config writes issued once after power-up, as {addr, data}
   localparam logic [15:0] INIT_CMD [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};

   // Read order: pitch rate low/high, then Z accel low/high
   localparam logic [7:0] RD_ADDR [4] = '{8'hA2, 8'hA3, 8'hAC, 8'hAD};

   localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for the asynchronous IMU interrupt plus a rising-edge pulse.
module int_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic sync_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         sync_d <= sync_q;
      end
   end

   assign rise = sync_q & ~sync_d;

endmodule

// File: rtl/imu_read_sequencer.sv
// IMU sequencer: configures the IMU after power-up, then reads pitch rate and Z accel per interrupt.
// Optional macro IMU_TIMEOUT_EN adds a per-transaction timeout with retry and sticky timeout_err.
module imu_read_sequencer
   import imu_seq_pkg::*;
#(
   parameter int INIT_WAIT_W = 16
`ifdef IMU_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ,
   output logic        vld,
`ifdef IMU_TIMEOUT_EN
   output logic        timeout_err,
`endif
   output logic        init_done
);

   seq_state_t             state;
   logic [INIT_WAIT_W-1:0] wait_cnt;
   logic [1:0]             idx;
   logic                   issue;
   logic                   busy;
   logic                   pending;
   logic [2:0][7:0]        byte_q;
   logic                   int_rise;
   logic                   rd_data_unused;

`ifdef IMU_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [TCNT_W-1:0] tcnt;
`endif

   assign rd_data_unused = ^rd_data[15:8];

   int_sync_edge u_int_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (INT),
      .rise     (int_rise)
   );

   // issue requests a wrt on the next cycle; busy marks a transaction awaiting done.
   // The last read byte goes straight from rd_data to AZ so vld follows done by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT_WAIT;
         wait_cnt  <= '0;
         idx       <= 2'd0;
         issue     <= 1'b0;
         busy      <= 1'b0;
         pending   <= 1'b0;
         byte_q    <= '0;
         wrt       <= 1'b0;
         cmd       <= 16'h0000;
         ptch_rt   <= 16'h0000;
         AZ        <= 16'h0000;
         vld       <= 1'b0;
         init_done <= 1'b0;
`ifdef IMU_TIMEOUT_EN
         tcnt        <= '0;
         timeout_err <= 1'b0;
`endif
      end else begin
         wrt <= 1'b0;
         vld <= 1'b0;
         if (int_rise && ((state == RD) || (state == OUT)))
            pending <= 1'b1;

         case (state)
            INIT_WAIT: begin
               if (wait_cnt == '1) begin
                  state <= INIT_WR;
                  idx   <= 2'd0;
                  issue <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            INIT_WR, RD: begin
               if (issue) begin
                  wrt   <= 1'b1;
                  issue <= 1'b0;
                  busy  <= 1'b1;
                  cmd   <= (state == INIT_WR) ? INIT_CMD[idx] : {RD_ADDR[idx], 8'h00};
`ifdef IMU_TIMEOUT_EN
                  tcnt  <= '0;
`endif
               end else if (busy && done) begin
                  busy <= 1'b0;
                  if ((state == RD) && (idx != 2'd3))
                     byte_q[idx] <= rd_data[7:0];
                  if (idx == 2'd3) begin
                     if (state == INIT_WR) begin
                        init_done <= 1'b1;
                        state     <= IDLE;
                     end else begin
                        ptch_rt <= {byte_q[1], byte_q[0]};
                        AZ      <= {rd_data[7:0], byte_q[2]};
                        vld     <= 1'b1;
                        state   <= OUT;
                     end
                  end else begin
                     idx   <= idx + 2'd1;
                     issue <= 1'b1;
                  end
               end
`ifdef IMU_TIMEOUT_EN
               else if (busy) begin
                  if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
                     timeout_err <= 1'b1;
                     busy        <= 1'b0;
                     issue       <= 1'b1;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
`endif
            end

            IDLE: begin
               if (int_rise || pending) begin
                  state   <= RD;
                  idx     <= 2'd0;
                  issue   <= 1'b1;
                  pending <= 1'b0;
               end
            end

            OUT: state <= IDLE;

            default: state <= INIT_WAIT;
         endcase
      end
   end

endmodule
